// File: rtl/irq_w0c_pkg.sv
// rtl/irq_w0c_pkg.sv - shared state encoding and constants for irq_w0c_reader
//
// Purpose : state typedef for the W0C status service FSM plus the register
//           recovery delay applied after the clear write.
// Ports   : none (package).

package irq_w0c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_IRQ,
    ST_SNAP,
    ST_CLR,
    ST_RECOV
  } state_e;

  // Cycles the status register needs to reflect the clear before pend is trusted again.
  localparam int RECOV_CYC = 1;

endpackage

// File: rtl/irq_w0c_reader.sv
// rtl/irq_w0c_reader.sv - interrupt, snapshot read and W0C acknowledge for sticky status bits
//
// Purpose : watches a bank of write-0-to-clear sticky status bits, raises a
//           holdoff-delayed level interrupt, snapshots masked status on a read
//           request and then issues the W0C write that clears exactly the
//           snapshotted bits.
// Ports   :
//   clk        in  clock
//   rst_n      in  asynchronous active-low reset
//   stat       in  [BITS_W]    sticky status (register dout)
//   hw_set     in  [BITS_W]    hardware set vector of the same register
//   mask       in  [BITS_W]    1 = bit enabled for interrupt and service
//   holdoff    in  [HOLDOFF_W] cycles from pending to irq, 0 = next cycle
//   rd_req     in  single-cycle read request, sampled only while rd_rdy=1
//   rd_rdy     out read request can be accepted (IDLE/HOLD/IRQ)
//   rd_ack     out single-cycle pulse, rd_dat valid
//   rd_dat     out [BITS_W]    snapshot of stat & mask
//   irq        out level interrupt
//   clr_w_en   out W0C write strobe
//   clr_w_dat  out [BITS_W]    W0C write data (~snapshot)

module irq_w0c_reader
  import irq_w0c_pkg::*;
#(
  parameter int BITS_W    = 8,
  parameter int HOLDOFF_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BITS_W-1:0]    stat,
  input  logic [BITS_W-1:0]    hw_set,
  input  logic [BITS_W-1:0]    mask,
  input  logic [HOLDOFF_W-1:0] holdoff,
  input  logic                 rd_req,
  output logic                 rd_rdy,
  output logic                 rd_ack,
  output logic [BITS_W-1:0]    rd_dat,
  output logic                 irq,
  output logic                 clr_w_en,
  output logic [BITS_W-1:0]    clr_w_dat
);

  state_e                 state_q, state_d;
  logic [HOLDOFF_W-1:0]   cnt_q, cnt_d;
  logic [BITS_W-1:0]      snap_q, snap_d;
  logic                   pend;

  assign pend = |(stat & mask);

  // Outputs are pure state decodes; clr_w_en also looks at hw_set because the
  // register drops w_en whenever a hardware set is present in the same cycle.
  assign rd_rdy    = (state_q == ST_IDLE) || (state_q == ST_HOLD) || (state_q == ST_IRQ);
  assign rd_ack    = (state_q == ST_SNAP);
  assign rd_dat    = snap_q;
  assign irq       = (state_q == ST_IRQ);
  assign clr_w_en  = (state_q == ST_CLR) && (hw_set == '0);
  assign clr_w_dat = (state_q == ST_CLR) ? ~snap_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;

    // A read accepted in any ready state wins over interrupt sequencing.
    if (rd_rdy && rd_req) begin
      state_d = ST_SNAP;
      snap_d  = stat & mask;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend) begin
            if (holdoff == '0) begin
              state_d = ST_IRQ;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = holdoff - HOLDOFF_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (!pend) begin
            state_d = ST_IDLE;
          end else if (cnt_q == '0) begin
            state_d = ST_IRQ;
          end else begin
            cnt_d = cnt_q - HOLDOFF_W'(1);
          end
        end
        ST_IRQ: begin
          if (!pend) begin
            state_d = ST_IDLE;
          end
        end
        ST_SNAP: begin
          // Nothing was captured, so there is nothing to acknowledge.
          state_d = (snap_q == '0) ? ST_IDLE : ST_CLR;
        end
        ST_CLR: begin
          if (clr_w_en) begin
            state_d = ST_RECOV;
            cnt_d   = HOLDOFF_W'(RECOV_CYC - 1);
          end
        end
        ST_RECOV: begin
          if (cnt_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q - HOLDOFF_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_w0c_reader.sv
// tb/tb_irq_w0c_reader.sv - directed self-checking bench for irq_w0c_reader

module tb_irq_w0c_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] stat;
  logic [7:0] hw_set;
  logic [7:0] mask;
  logic [3:0] holdoff;
  logic       rd_req;
  logic       rd_rdy;
  logic       rd_ack;
  logic [7:0] rd_dat;
  logic       irq;
  logic       clr_w_en;
  logic [7:0] clr_w_dat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_w0c_reader #(.BITS_W(8), .HOLDOFF_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stat      (stat),
    .hw_set    (hw_set),
    .mask      (mask),
    .holdoff   (holdoff),
    .rd_req    (rd_req),
    .rd_rdy    (rd_rdy),
    .rd_ack    (rd_ack),
    .rd_dat    (rd_dat),
    .irq       (irq),
    .clr_w_en  (clr_w_en),
    .clr_w_dat (clr_w_dat)
  );

  // W0C register model: hardware set has priority over the write, which is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              stat <= 8'h00;
    else if (hw_set != 8'h00) stat <= stat | hw_set;
    else if (clr_w_en)        stat <= stat & clr_w_dat;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a read and wait for the FSM to come back ready; returns with hw_set idle.
  task automatic read_and_clear(input string tag);
    int n;
    hw_set = 8'h00;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    n = 0;
    while (!rd_rdy && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ready"}, {7'd0, rd_rdy}, 8'h01);
  endtask

  initial begin
    rst_n   = 1'b0;
    hw_set  = 8'h00;
    mask    = 8'hFF;
    holdoff = 4'd0;
    rd_req  = 1'b0;
    tick();
    tick();
    chk("rst_irq",    {7'd0, irq},      8'h00);
    chk("rst_ack",    {7'd0, rd_ack},   8'h00);
    chk("rst_wen",    {7'd0, clr_w_en}, 8'h00);
    chk("rst_rddat",  rd_dat,           8'h00);
    chk("rst_wdat",   clr_w_dat,        8'h00);
    chk("rst_rdy",    {7'd0, rd_rdy},   8'h01);
    rst_n = 1'b1;
    tick();

    // 1: holdoff 0, pulse 05
    hw_set = 8'h05;
    tick();
    hw_set = 8'h00;
    chk("t1_stat", stat, 8'h05);
    chk("t1_irq_t1", {7'd0, irq}, 8'h00);
    tick();
    chk("t1_irq_t2", {7'd0, irq}, 8'h01);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("t1_ack", {7'd0, rd_ack}, 8'h01);
    chk("t1_rddat", rd_dat, 8'h05);
    chk("t1_irq_snap", {7'd0, irq}, 8'h00);
    tick();
    chk("t1_wen", {7'd0, clr_w_en}, 8'h01);
    chk("t1_wdat", clr_w_dat, 8'hFA);
    tick();
    chk("t1_stat_clr", stat, 8'h00);
    chk("t1_wen_off", {7'd0, clr_w_en}, 8'h00);
    chk("t1_rdy_recov", {7'd0, rd_rdy}, 8'h00);
    tick();
    chk("t1_rdy_idle", {7'd0, rd_rdy}, 8'h01);
    tick();
    chk("t1_irq_after", {7'd0, irq}, 8'h00);

    // 2: holdoff 3
    holdoff = 4'd3;
    hw_set = 8'h01;
    tick();
    hw_set = 8'h00;
    tick();
    tick();
    tick();
    chk("t2_irq_t3", {7'd0, irq}, 8'h00);
    tick();
    chk("t2_irq_t4", {7'd0, irq}, 8'h01);
    read_and_clear("t2a");
    chk("t2_stat_clr", stat, 8'h00);
    hw_set = 8'h01;
    tick();
    hw_set = 8'h00;
    tick();
    mask = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_irq_masked", {7'd0, irq}, 8'h00);
    end
    mask = 8'hFF;
    holdoff = 4'd0;
    tick();
    tick();
    chk("t2_irq_unmask", {7'd0, irq}, 8'h01);
    read_and_clear("t2b");

    // 3: CLR stalled by hw_set
    hw_set = 8'h03;
    tick();
    hw_set = 8'h00;
    tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("t3_rddat", rd_dat, 8'h03);
    tick();
    hw_set = 8'h10;
    #1;
    chk("t3_wen_c1", {7'd0, clr_w_en}, 8'h00);
    tick();
    chk("t3_wen_c2", {7'd0, clr_w_en}, 8'h00);
    tick();
    chk("t3_wen_c3", {7'd0, clr_w_en}, 8'h00);
    tick();
    hw_set = 8'h00;
    #1;
    chk("t3_wen_c4", {7'd0, clr_w_en}, 8'h01);
    chk("t3_wdat", clr_w_dat, 8'hFC);
    tick();
    chk("t3_stat", stat, 8'h10);
    tick();
    tick();
    chk("t3_irq_again", {7'd0, irq}, 8'h01);
    read_and_clear("t3");
    chk("t3_stat_clr", stat, 8'h00);

    // 4: bit set after the snapshot survives the clear
    hw_set = 8'h01;
    tick();
    hw_set = 8'h00;
    tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    hw_set = 8'h80;
    chk("t4_rddat", rd_dat, 8'h01);
    tick();
    hw_set = 8'h00;
    #1;
    chk("t4_wdat", clr_w_dat, 8'hFE);
    tick();
    chk("t4_stat", stat, 8'h80);
    tick();
    tick();
    chk("t4_irq", {7'd0, irq}, 8'h01);
    read_and_clear("t4");

    // 5: polling read with no status, then rd_req while in CLR
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("t5_ack", {7'd0, rd_ack}, 8'h01);
    chk("t5_rddat", rd_dat, 8'h00);
    chk("t5_wen_snap", {7'd0, clr_w_en}, 8'h00);
    tick();
    chk("t5_wen_idle", {7'd0, clr_w_en}, 8'h00);
    chk("t5_rdy", {7'd0, rd_rdy}, 8'h01);
    hw_set = 8'h04;
    tick();
    hw_set = 8'h00;
    tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    hw_set = 8'h20;
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk("t5_no_ack1", {7'd0, rd_ack}, 8'h00);
    hw_set = 8'h00;
    tick();
    chk("t5_no_ack2", {7'd0, rd_ack}, 8'h00);
    chk("t5_stat", stat, 8'h20);
    tick();
    tick();
    read_and_clear("t5");

    // 6: reset while the clear write is being driven
    hw_set = 8'h02;
    tick();
    hw_set = 8'h00;
    tick();
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    chk("t6_wen_pre", {7'd0, clr_w_en}, 8'h01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_wen_rst", {7'd0, clr_w_en}, 8'h00);
    chk("t6_irq_rst", {7'd0, irq}, 8'h00);
    chk("t6_rddat_rst", rd_dat, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_rdy", {7'd0, rd_rdy}, 8'h01);
    chk("t6_irq", {7'd0, irq}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
